// File: rtl/pkt_hdr_pkg.sv
// Shared definitions for the packet header inserter.
// Holds the default magic word, the header field layout, the FSM state type
// and a helper that assembles a header beat from its fields.
package pkt_hdr_pkg;

  localparam int unsigned TDATA_W = 512;

  localparam logic [31:0] MAGIC_DEFAULT = 32'hC0DE_5A5A;

  // Header field layout within the 512-bit beat; everything above the ID is zero.
  localparam int unsigned HDR_MAGIC_LSB = 0;
  localparam int unsigned HDR_MAGIC_W   = 32;
  localparam int unsigned HDR_SEQ_LSB   = 32;
  localparam int unsigned HDR_SEQ_W     = 32;
  localparam int unsigned HDR_SIZE_LSB  = 64;
  localparam int unsigned HDR_SIZE_W    = 16;
  localparam int unsigned HDR_ID_LSB    = 80;
  localparam int unsigned HDR_ID_W      = 8;

  // Payload beats are 64 bytes, so the beat count is PACKET_SIZE[15:6].
  localparam int unsigned BEAT_CNT_W   = 10;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;

  typedef enum logic {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  function automatic logic [TDATA_W-1:0] build_header(
    input logic [HDR_MAGIC_W-1:0] magic,
    input logic [HDR_SEQ_W-1:0]   seq,
    input logic [HDR_SIZE_W-1:0]  size,
    input logic [HDR_ID_W-1:0]    id
  );
    logic [TDATA_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: HDR_MAGIC_W] = magic;
    hdr[HDR_SEQ_LSB   +: HDR_SEQ_W]   = seq;
    hdr[HDR_SIZE_LSB  +: HDR_SIZE_W]  = size;
    hdr[HDR_ID_LSB    +: HDR_ID_W]    = id;
    return hdr;
  endfunction

endpackage

// File: rtl/pkt_length_checker.sv
// Per-packet length check for the header inserter.
// Latches the expected beat count when a header goes out, counts payload
// handshakes, and at TLAST compares the two. Mismatches bump a saturating
// error counter. An expected count of zero disables the check.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   i_hdr_fire         header beat handshake (start of packet)
//   i_expected_beats   PACKET_SIZE[15:6], sampled on i_hdr_fire
//   i_beat_fire        payload beat handshake
//   i_last_fire        payload beat handshake carrying TLAST
//   o_size_errors      saturating count of mis-sized packets
module pkt_length_checker
  import pkt_hdr_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_hdr_fire,
  input  logic [BEAT_CNT_W-1:0] i_expected_beats,
  input  logic                  i_beat_fire,
  input  logic                  i_last_fire,
  output logic [15:0]           o_size_errors
);

  logic [BEAT_CNT_W-1:0] r_beat_count;
  logic [BEAT_CNT_W-1:0] r_expected_beats;
  logic [15:0]           r_size_errors;

  logic [BEAT_CNT_W-1:0] w_beat_count_inc;
  logic [BEAT_CNT_W:0]   w_beats_seen;
  logic                  w_len_bad;
  logic [15:0]           w_size_errors_d;

  // Saturate so an over-long packet can never wrap back into a "match".
  assign w_beat_count_inc = (r_beat_count == BEAT_CNT_MAX) ? r_beat_count
                                                           : r_beat_count + 1'b1;

  // One bit wider: a saturated count plus the TLAST beat reads as 1024,
  // which no latched expectation can equal.
  assign w_beats_seen = {1'b0, r_beat_count} + 1'b1;

  assign w_len_bad = i_last_fire && (r_expected_beats != '0) &&
                     (w_beats_seen != {1'b0, r_expected_beats});

  assign w_size_errors_d = (w_len_bad && (r_size_errors != 16'hFFFF)) ? r_size_errors + 16'd1
                                                                       : r_size_errors;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_beat_count     <= '0;
      r_expected_beats <= '0;
      r_size_errors    <= '0;
    end else begin
      if (i_hdr_fire) begin
        r_beat_count     <= '0;
        r_expected_beats <= i_expected_beats;
      end else if (i_beat_fire) begin
        r_beat_count <= w_beat_count_inc;
      end
      r_size_errors <= w_size_errors_d;
    end
  end

  assign o_size_errors = r_size_errors;

endmodule

// File: rtl/packet_header_inserter.sv
// Prepends one 64-byte header beat to every TLAST-delimited packet of a
// 512-bit AXI-Stream. Payload beats pass straight through; the header carries
// MAGIC, a per-stream sequence number, the configured PACKET_SIZE and
// STREAM_ID so the host can spot dropped or reordered packets.
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   i_packet_size                    payload bytes per packet (multiple of 64)
//   i_axis_in_tdata/tlast/tvalid     payload stream in
//   o_axis_in_tready                 payload stream ready
//   o_axis_out_tdata/tlast/tvalid    header + payload stream out
//   i_axis_out_tready                output ready
//   o_packets_sent                   completed packets (wraps)
//   o_size_errors                    packets with unexpected beat count (saturates)
module packet_header_inserter
  import pkt_hdr_pkg::*;
#(
  parameter logic [7:0]  STREAM_ID = 8'd0,
  parameter logic [31:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [15:0]        i_packet_size,
  input  logic [TDATA_W-1:0] i_axis_in_tdata,
  input  logic               i_axis_in_tlast,
  input  logic               i_axis_in_tvalid,
  output logic               o_axis_in_tready,
  output logic [TDATA_W-1:0] o_axis_out_tdata,
  output logic               o_axis_out_tlast,
  output logic               o_axis_out_tvalid,
  input  logic               i_axis_out_tready,
  output logic [31:0]        o_packets_sent,
  output logic [15:0]        o_size_errors
);

  state_t      r_state;
  logic [31:0] r_seq;
  logic [31:0] r_packets_sent;

  logic               w_hdr_fire;
  logic               w_beat_fire;
  logic               w_last_fire;
  logic [31:0]        w_seq_d;
  logic [TDATA_W-1:0] w_header;

  // The header only goes out once the first payload beat is waiting, so a
  // header handshake needs upstream valid as well as downstream ready.
  assign w_hdr_fire  = (r_state == HDR)     && i_axis_in_tvalid && i_axis_out_tready;
  assign w_beat_fire = (r_state == PAYLOAD) && i_axis_in_tvalid && i_axis_out_tready;
  assign w_last_fire = w_beat_fire && i_axis_in_tlast;

  assign w_seq_d  = w_hdr_fire ? r_seq + 32'd1 : r_seq;
  assign w_header = build_header(MAGIC, r_seq, i_packet_size, STREAM_ID);

  always_comb begin
    o_axis_out_tvalid = i_axis_in_tvalid;
    o_axis_out_tdata  = i_axis_in_tdata;
    o_axis_out_tlast  = 1'b0;
    o_axis_in_tready  = 1'b0;
    unique case (r_state)
      HDR: begin
        o_axis_out_tdata = w_header;
      end
      PAYLOAD: begin
        o_axis_out_tlast = i_axis_in_tlast;
        o_axis_in_tready = i_axis_out_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= HDR;
      r_seq          <= '0;
      r_packets_sent <= '0;
    end else begin
      r_seq <= w_seq_d;
      unique case (r_state)
        HDR: begin
          if (w_hdr_fire) begin
            r_state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_last_fire) begin
            r_state        <= HDR;
            r_packets_sent <= r_packets_sent + 32'd1;
          end
        end
        default: r_state <= HDR;
      endcase
    end
  end

  pkt_length_checker u_len_chk (
    .clk              (clk),
    .resetn           (resetn),
    .i_hdr_fire       (w_hdr_fire),
    .i_expected_beats (i_packet_size[15:6]),
    .i_beat_fire      (w_beat_fire),
    .i_last_fire      (w_last_fire),
    .o_size_errors    (o_size_errors)
  );

  assign o_packets_sent = r_packets_sent;

endmodule
